// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline fetch/data ports and single-port RAM bus shared through the arbiter
//   i_req/i_addr -> i_rdata/i_ack                  IF-stage fetch handshake
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack     MEM-stage load/store handshake
//   ram_en/ram_we/ram_addr/ram_wdata -> ram_rdata  unified RAM access
//   slave modport: arbiter side; master modport: pipeline/RAM side
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and data ports, data-first with starvation guard
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave: fetch/data handshakes in, RAM access out; all outputs registered
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RAM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int LW = $clog2(RAM_LAT + 1);
    localparam int SW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state, state_nxt;
    logic              own_i, own_i_nxt;
    logic              we_l, we_l_nxt;
    logic [LW-1:0]     lat_cnt, lat_cnt_nxt;
    logic [SW-1:0]     starve_cnt, starve_cnt_nxt;
    logic              ram_en_nxt, ram_we_nxt, i_ack_nxt, d_ack_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
    logic              pick_i;

    // fetch wins only when alone or when the data port has had its MAX_WAIT turns
    assign pick_i = bus.i_req && (!bus.d_req || starve_cnt == SW'(MAX_WAIT));

    always_comb begin
        state_nxt      = state;
        own_i_nxt      = own_i;
        we_l_nxt       = we_l;
        lat_cnt_nxt    = lat_cnt;
        starve_cnt_nxt = starve_cnt;
        ram_en_nxt     = 1'b0;
        ram_we_nxt     = 1'b0;
        ram_addr_nxt   = bus.ram_addr;
        ram_wdata_nxt  = bus.ram_wdata;
        i_ack_nxt      = 1'b0;
        d_ack_nxt      = 1'b0;
        i_rdata_nxt    = '0;
        d_rdata_nxt    = '0;
        case (state)
            IDLE: begin
                // a data grant with fetch waiting cannot occur at MAX_WAIT, so no saturation test is needed
                starve_cnt_nxt = (!bus.i_req || pick_i) ? '0 : starve_cnt + 1'b1;
                if (bus.i_req || bus.d_req) begin
                    state_nxt     = ISSUE;
                    own_i_nxt     = pick_i;
                    we_l_nxt      = !pick_i && bus.d_we;
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = !pick_i && bus.d_we;
                    ram_addr_nxt  = pick_i ? bus.i_addr : bus.d_addr;
                    ram_wdata_nxt = bus.d_wdata;
                end
            end
            ISSUE: begin
                state_nxt   = WAIT;
                lat_cnt_nxt = LW'(RAM_LAT - 1);
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt   = ACK;
                    i_ack_nxt   = own_i;
                    d_ack_nxt   = !own_i;
                    i_rdata_nxt = own_i ? bus.ram_rdata : '0;
                    d_rdata_nxt = (!own_i && !we_l) ? bus.ram_rdata : '0;
                end else begin
                    lat_cnt_nxt = lat_cnt - 1'b1;
                end
            end
            ACK: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            own_i         <= 1'b0;
            we_l          <= 1'b0;
            lat_cnt       <= '0;
            starve_cnt    <= '0;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.i_ack     <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
        end else begin
            state         <= state_nxt;
            own_i         <= own_i_nxt;
            we_l          <= we_l_nxt;
            lat_cnt       <= lat_cnt_nxt;
            starve_cnt    <= starve_cnt_nxt;
            bus.ram_en    <= ram_en_nxt;
            bus.ram_we    <= ram_we_nxt;
            bus.ram_addr  <= ram_addr_nxt;
            bus.ram_wdata <= ram_wdata_nxt;
            bus.i_ack     <= i_ack_nxt;
            bus.d_ack     <= d_ack_nxt;
            bus.i_rdata   <= i_rdata_nxt;
            bus.d_rdata   <= d_rdata_nxt;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboarded check of the arbiter with RAM models at latency 1 and 3
module tb_mem_port_arbiter;
    typedef struct packed {
        logic        is_i;
        logic [31:0] data;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    exp_t  sb[$];
    logic  prev_i = 1'b0, prev_d = 1'b0;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus3 ();

    mem_port_arbiter u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    mem_port_arbiter #(.RAM_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    logic [31:0] mem [0:1023];
    logic [31:0] pipe1;
    logic [31:0] p0, p1, p2;

    always @(posedge clk) begin
        pipe1 <= bus.ram_en ? mem[bus.ram_addr[9:0]] : 32'hBAD0_BAD0;
        if (bus.ram_en && bus.ram_we) mem[bus.ram_addr[9:0]] = bus.ram_wdata;
    end
    assign bus.ram_rdata = pipe1;

    always @(posedge clk) begin
        p0 <= bus3.ram_en ? pat(bus3.ram_addr) : 32'hBAD0_BAD0;
        p1 <= p0;
        p2 <= p1;
    end
    assign bus3.ram_rdata = p2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus.i_ack) check("i_rdata_idle", bus.i_rdata, 32'h0);
            if (!bus.d_ack) check("d_rdata_idle", bus.d_rdata, 32'h0);
            if (bus.i_ack || bus.d_ack) begin
                check("ack_width", 32'({bus.i_ack & prev_i, bus.d_ack & prev_d}), 32'h0);
                if (sb.size() == 0) begin
                    check("unexp_ack", 32'({bus.i_ack, bus.d_ack}), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_port", 32'({bus.i_ack, bus.d_ack}), e.is_i ? 32'h2 : 32'h1);
                    check("rdata", bus.i_ack ? bus.i_rdata : bus.d_rdata, e.data);
                end
            end
        end
        prev_i <= bus.i_ack;
        prev_d <= bus.d_ack;
    end

    task automatic wait_ack(input bit port_i, output int t);
        t = -1;
        for (int k = 0; k < 40 && t < 0; k++) begin
            @(negedge clk);
            if (port_i ? bus.i_ack : bus.d_ack) t = cyc;
        end
        if (t < 0) check(port_i ? "i_ack_timeout" : "d_ack_timeout", 32'h0, 32'h1);
    endtask

    task automatic data_op(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] e);
        int t;
        sb.push_back('{1'b0, e});
        bus.d_we = we;
        bus.d_addr = a;
        bus.d_wdata = wd;
        bus.d_req = 1'b1;
        wait_ack(1'b0, t);
        bus.d_req = 1'b0;
    endtask

    initial begin
        int t1, t2, n_ack;
        for (int i = 0; i < 1024; i++) mem[i] = pat(32'(i));
        mem[16] = 32'h2002_000A;
        {bus.i_req, bus.d_req, bus.d_we} = '0;
        {bus.i_addr, bus.d_addr, bus.d_wdata} = '0;
        {bus3.i_req, bus3.d_req, bus3.d_we} = '0;
        {bus3.i_addr, bus3.d_addr, bus3.d_wdata} = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'({bus.ram_en, bus.ram_we, bus.i_ack, bus.d_ack}), 32'h0);
        check("reset_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // reset while the RAM strobe is up: access abandoned without ack
        bus.d_addr = 32'h70;
        bus.d_req = 1'b1;
        @(negedge clk);
        check("pre_rst_en", 32'(bus.ram_en), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({bus.ram_en, bus.i_ack, bus.d_ack}), 32'h0);
        @(negedge clk);
        bus.d_req = 1'b0;
        rst_n = 1'b1;
        n_ack = 0;
        repeat (8) begin
            @(negedge clk);
            n_ack += int'(bus.i_ack) + int'(bus.d_ack);
        end
        check("rst_no_ack", 32'(n_ack), 32'h0);

        // lone fetch, cycle exact
        sb.push_back('{1'b1, 32'h2002_000A});
        bus.i_addr = 32'h10;
        bus.i_req = 1'b1;
        @(negedge clk);
        check("f_e0_en", 32'({bus.ram_en, bus.ram_we}), 32'h2);
        check("f_e0_addr", bus.ram_addr, 32'h10);
        @(negedge clk);
        check("f_e1", 32'({bus.ram_en, bus.i_ack, bus.d_ack}), 32'h0);
        @(negedge clk);
        check("f_e2_ack", 32'({bus.i_ack, bus.d_ack}), 32'h2);
        check("f_e2_data", bus.i_rdata, 32'h2002_000A);
        bus.i_req = 1'b0;
        @(negedge clk);
        check("f_e3_ack", 32'(bus.i_ack), 32'h0);

        // store then load back
        data_op(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0);
        data_op(1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
        data_op(1'b0, 32'h123, 32'h0, pat(32'h123));

        // simultaneous requests: data first, fetch four cycles later
        sb.push_back('{1'b0, pat(32'h20)});
        sb.push_back('{1'b1, pat(32'h30)});
        bus.d_we = 1'b0;
        bus.d_addr = 32'h20;
        bus.i_addr = 32'h30;
        bus.d_req = 1'b1;
        bus.i_req = 1'b1;
        wait_ack(1'b0, t1);
        bus.d_req = 1'b0;
        wait_ack(1'b1, t2);
        bus.i_req = 1'b0;
        check("ack_gap", 32'(t2 - t1), 32'h4);

        // starvation: four data grants, then fetch forced
        for (int k = 0; k < 4; k++) sb.push_back('{1'b0, pat(32'h50)});
        sb.push_back('{1'b1, pat(32'h40)});
        bus.d_addr = 32'h50;
        bus.i_addr = 32'h40;
        bus.d_req = 1'b1;
        bus.i_req = 1'b1;
        for (int k = 0; k < 4; k++) wait_ack(1'b0, t1);
        wait_ack(1'b1, t2);
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        @(negedge clk);
        check("starve_cnt", 32'(u_dut.starve_cnt), 32'h0);
        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'h0);

        // RAM_LAT=3 lone load
        bus3.d_addr = 32'h60;
        bus3.d_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("l3_ram_en", 32'(bus3.ram_en), 32'(k == 0));
            check("l3_d_ack", 32'(bus3.d_ack), 32'(k == 4));
            if (k == 4) begin
                check("l3_d_rdata", bus3.d_rdata, pat(32'h60));
                bus3.d_req = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
